device_id_reader: RTL
=====================

Name: device_id_reader

Overview:
- Parametrised successor to the shell's fixed 96-bit DNA reader. Sequences a Xilinx DNA_PORT-family primitive: wait, load, then W serial shifts.
- Captures the ID LSB-first into a held parallel register and mirrors each bit on a serial tap.
- Re-emits the ID as a valid/ready word stream for register-file or mailbox consumers.
- The primitive is instantiated outside this block, in the shell wrapper, so one block serves DNA_PORT (57 bits) and DNA_PORTE2 (96 bits).

Parameters:
- ID_W, 96, ID length in bits (1..256).
- WORD_W, 32, stream word width (1..64).
- STARTUP_DLY, 9, idle cycles between start and READ pulse (0..255).
- AUTO_START, 1, 1 = launch one read automatically after reset release.

Ports:
- clk  in  1  single clock for all logic and the primitive CLK.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to (re)read the ID; honoured only in IDLE.
- busy  out  1  high from acceptance of start until the last stream word is accepted.
- prim_read  out  1  to primitive READ.
- prim_shift  out  1  to primitive SHIFT.
- prim_din  out  1  to primitive DIN; equals prim_dout, a rotate loopback so a re-read is non-destructive.
- prim_dout  in  1  from primitive DOUT.
- ser_out  out  1  registered copy of the sampled bit.
- ser_valid  out  1  qualifies ser_out, one pulse per captured bit.
- id_out  out  ID_W  captured ID, bit0 = first bit shifted out.
- id_valid  out  1  sticky; set when capture completes.
- m_data  out  WORD_W  stream word.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word.

Behaviour:
- Reset: all outputs 0, state IDLE, id_out 0.
  - Reset is asynchronous and may assert mid-operation.
  - When rst_n releases with AUTO_START=1, the FSM enters WAIT on the first clk edge, exactly as if start had been asserted.
- States: IDLE -> WAIT -> LOAD -> SHIFT -> STREAM -> IDLE.
- IDLE: busy=0. start=1 moves to WAIT, clears the delay counter, sets busy=1 next cycle and clears id_valid.
- WAIT: holds for STARTUP_DLY cycles. STARTUP_DLY=0 skips straight to LOAD.
- LOAD: prim_read=1 for exactly one cycle; prim_shift=0.
- SHIFT: prim_shift=1 for exactly ID_W consecutive cycles.
  - On every edge where the registered prim_shift is 1: id_shift <= {prim_dout, id_shift[ID_W-1:1]}, ser_out <= prim_dout, ser_valid <= 1.
  - After ID_W shifts, id_out <= the final shift value and id_valid <= 1 on the same edge that enters STREAM.
- Latency: start sampled at edge 0 -> id_valid high after edge STARTUP_DLY+ID_W+2.
- STREAM: NW = ceil(ID_W/WORD_W) words, word 0 first.
  - Word k = id_out[k*WORD_W +: WORD_W]; bits above ID_W in the last word are 0.
  - m_valid is held until m_ready. m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_last=1 only on word NW-1. Accepting word NW-1 returns to IDLE and drops busy on the next cycle.
- start while busy=1 is ignored; no queuing.
- start in the same cycle as the final handshake is ignored, because the FSM is not yet in IDLE.
- Reset mid-SHIFT or mid-STREAM: id_out and id_valid clear; the stream aborts with no m_last.
- id_out holds its value across IDLE until the next completed capture. It is never partially updated.
- Counters are sized for ID_W and STARTUP_DLY maxima; the shift counter must not wrap inside SHIFT.

Optional Feature:
- Macro: DEVICE_ID_COMPARE_EN.
- When defined:
  - Adds input exp_id[ID_W-1:0] and outputs id_match and id_mismatch.
  - Both outputs are registered and update on the edge that sets id_valid: id_match = (capture == exp_id), id_mismatch is its inverse.
  - Both are 0 whenever id_valid=0.
- When undefined: these ports do not exist and no comparator is built.

Test Plan:
- ID_W=96, WORD_W=32, STARTUP_DLY=9, primitive model loaded with 96'h0123_4567_89AB_CDEF_FEDC_BA98, AUTO_START=1, m_ready=1 -> prim_read pulses once at cycle 10 after reset. prim_shift is high exactly 96 cycles. ser_valid pulses 96 times. id_out = model value. Words are 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567, with m_last on the third.
- ID_W=57, WORD_W=32, model value 57'h1AB_CDEF_0123_4567 -> words 32'h01234567, then 32'h01ABCDEF with bits 31:25 zero. m_last on the second word.
- Backpressure: hold m_ready=0 for 5 cycles per word -> m_data stable while stalled, no word lost or duplicated, busy held until the final handshake.
- start pulsed mid-SHIFT and again on the final handshake cycle -> both ignored, exactly one READ pulse. A later start in IDLE re-reads the same value thanks to the rotate loopback.
- rst_n low at shift bit 40, released, AUTO_START=0 -> all outputs 0, no stream activity. start then yields a correct full capture.
- DEVICE_ID_COMPARE_EN defined: exp_id equal to the model -> id_match=1 on the id_valid edge. exp_id with bit 95 flipped -> id_mismatch=1. Both 0 before capture.

Source files
------------

// File: rtl/device_id_reader.sv
// device_id_reader: sequences a DNA_PORT-family primitive (startup wait, one READ, ID_W SHIFTs),
// captures the ID LSB-first into a held register, mirrors each bit on ser_out and replays the ID
// as a valid/ready word stream. Optional comparator against exp_id: define DEVICE_ID_COMPARE_EN.
module device_id_reader #(
  parameter int ID_W        = 96,
  parameter int WORD_W      = 32,
  parameter int STARTUP_DLY = 9,
  parameter bit AUTO_START  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              prim_read,
  output logic              prim_shift,
  output logic              prim_din,
  input  logic              prim_dout,
  output logic              ser_out,
  output logic              ser_valid,
  output logic [ID_W-1:0]   id_out,
  output logic              id_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef DEVICE_ID_COMPARE_EN
  ,
  input  logic [ID_W-1:0]   exp_id,
  output logic              id_match,
  output logic              id_mismatch
`endif
);

  localparam int NW    = (ID_W + WORD_W - 1) / WORD_W;
  localparam int PAD_W = NW * WORD_W;
  localparam logic [7:0] DLY_LAST  = 8'(STARTUP_DLY - 1);
  localparam logic [8:0] CAP_LAST  = 9'(ID_W - 1);
  localparam logic [8:0] CAP_TOTAL = 9'(ID_W);
  localparam logic [8:0] WORD_LAST = 9'(NW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_STREAM
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              auto_pend;
  logic [7:0]        dly_cnt;
  logic [8:0]        cap_cnt;
  logic [8:0]        word_idx;
  logic [ID_W-1:0]   id_shift;
  logic [ID_W-1:0]   id_shift_nxt;
  logic [PAD_W-1:0]  id_pad;
  logic              go;
  logic              cap_last;
  logic              shift_more;
  logic              accept;
  logic              last_word;

  // Rotate loopback: what leaves the primitive goes straight back in, so a re-read sees the same ID.
  assign prim_din = prim_dout;

  // Datapath decodes: capture pointer, shift issue window, stream word selection.
  always_comb begin
    go           = start | auto_pend;
    id_shift_nxt = id_shift >> 1;
    id_shift_nxt[ID_W-1] = prim_dout;
    // Last capture happens on the edge where the ID_W-th registered SHIFT is seen.
    cap_last     = prim_shift && (cap_cnt == CAP_LAST);
    // Keep SHIFT asserted until ID_W shifts have been issued (captured so far plus the one in flight).
    shift_more   = (state == S_SHIFT) && ((cap_cnt + {8'd0, prim_shift}) < CAP_TOTAL);
    busy         = (state != S_IDLE);
    m_valid      = (state == S_STREAM);
    last_word    = (word_idx == WORD_LAST);
    m_last       = m_valid && last_word;
    accept       = m_valid && m_ready;
    id_pad       = '0;
    id_pad[ID_W-1:0] = id_out;
    m_data       = WORD_W'(id_pad >> (int'(word_idx) * WORD_W));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so requests while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = (STARTUP_DLY == 0) ? S_LOAD : S_WAIT;
      S_WAIT:   if (dly_cnt == DLY_LAST) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SHIFT;
      S_SHIFT:  if (cap_last) state_nxt = S_STREAM;
      S_STREAM: if (accept && last_word) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // One-shot launch request after reset release when auto start is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_pend <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
    end
  end

  // Startup delay, capture and stream word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt  <= '0;
      cap_cnt  <= '0;
      word_idx <= '0;
    end else begin
      if (state == S_WAIT) dly_cnt <= dly_cnt + 8'd1;
      else                 dly_cnt <= '0;
      if (state == S_LOAD)  cap_cnt <= '0;
      else if (prim_shift)  cap_cnt <= cap_cnt + 9'd1;
      if (state != S_STREAM)          word_idx <= '0;
      else if (accept && !last_word)  word_idx <= word_idx + 9'd1;
    end
  end

  // Registered primitive controls: READ follows LOAD by one cycle, SHIFT follows the issue window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prim_read  <= 1'b0;
      prim_shift <= 1'b0;
    end else begin
      prim_read  <= (state == S_LOAD);
      prim_shift <= shift_more;
    end
  end

  // Serial capture on every edge that sees a registered SHIFT; each bit is mirrored on ser_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_shift  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      ser_valid <= prim_shift;
      if (prim_shift) begin
        id_shift <= id_shift_nxt;
        ser_out  <= prim_dout;
      end
    end
  end

  // Held ID: updated in one step at the end of capture, so consumers never see a partial value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_out   <= '0;
      id_valid <= 1'b0;
    end else if (state == S_IDLE && go) begin
      id_valid <= 1'b0;
    end else if (cap_last) begin
      id_out   <= id_shift_nxt;
      id_valid <= 1'b1;
    end
  end

`ifdef DEVICE_ID_COMPARE_EN
  // Expected-ID check, registered alongside id_valid and cleared whenever id_valid clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_match    <= 1'b0;
      id_mismatch <= 1'b0;
    end else if (state == S_IDLE && go) begin
      id_match    <= 1'b0;
      id_mismatch <= 1'b0;
    end else if (cap_last) begin
      id_match    <= (id_shift_nxt == exp_id);
      id_mismatch <= (id_shift_nxt != exp_id);
    end
  end
`endif

endmodule
